// File: rtl/memory_dp.sv
// memory_dp: simple dual-port synchronous memory with one write port and
// one read port, per-byte write enables, a read latency of 1 or 2 cycles,
// a selectable read-during-write policy and a hardware clear sequencer.
//
// Ports
//   clk       rising-edge clock for all logic
//   rst       asynchronous, active-low reset; restarts the clear sweep
//   clr       clear request, honoured only while idle
//   busy      high while the clear sweep runs; both user ports are ignored
//   wr_en     write request
//   wr_addr   write address (addresses >= DEPTH are dropped)
//   wr_data   write data
//   wr_be     byte enables, bit i selects wr_data[8i+7:8i]
//   rd_en     read request
//   rd_addr   read address (addresses >= DEPTH read as zero)
//   rd_data   read data, held between reads
//   rd_valid  one-cycle pulse marking new rd_data
module memory_dp #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR   = 8,
    parameter int RD_LAT = 1,
    parameter int BYPASS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    output logic               busy,
    input  logic               wr_en,
    input  logic [ADDR-1:0]    wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [WIDTH/8-1:0] wr_be,
    input  logic               rd_en,
    input  logic [ADDR-1:0]    rd_addr,
    output logic [WIDTH-1:0]   rd_data,
    output logic               rd_valid
);

    localparam int NB = WIDTH / 8;
    // One extra bit so DEPTH == 2**ADDR is representable in the range check.
    localparam logic [ADDR:0]   DEPTH_W  = (ADDR + 1)'(DEPTH);
    localparam logic [ADDR-1:0] LAST_IDX = ADDR'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  pipe_data_q, pipe_data_d;
    logic              pipe_valid_q, pipe_valid_d;
    logic [WIDTH-1:0]  rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_fire;
    logic              rd_fire;
    logic              mem_we;
    logic [ADDR-1:0]   mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [NB-1:0]     mem_wbe;
    logic [WIDTH-1:0]  rd_word;

    assign busy     = (state_q == CLEAR);
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

    // Sweep sequencer: the edge that clears DEPTH-1 returns to IDLE; clr is
    // only looked at while idle so a running sweep never restarts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // The sweep owns the write port while busy, so user writes are simply
    // not selected and can never collide with sweep writes.
    always_comb begin
        wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
        rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
        wr_fire     = wr_en && !busy && wr_in_range;
        rd_fire     = rd_en && !busy;
        mem_we      = 1'b0;
        mem_waddr   = wr_addr;
        mem_wdata   = wr_data;
        mem_wbe     = wr_be;
        if (busy) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
            mem_wbe   = '1;
        end else if (wr_fire) begin
            mem_we = 1'b1;
        end
    end

    // Read word: out-of-range reads return zero; in write-first mode a
    // same-address write is merged byte by byte into the old word.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem_q[rd_addr];
            if ((BYPASS != 0) && wr_fire && (wr_addr == rd_addr)) begin
                for (int i = 0; i < NB; i++) begin
                    if (wr_be[i]) begin
                        rd_word[8*i +: 8] = wr_data[8*i +: 8];
                    end
                end
            end
        end
    end

    // Output path: with RD_LAT=2 the read goes through an extra pipeline
    // register before the output register; reads already in that pipeline
    // complete even if a sweep starts behind them.
    always_comb begin
        pipe_data_d  = rd_fire ? rd_word : pipe_data_q;
        pipe_valid_d = rd_fire;
        if (RD_LAT == 2) begin
            rd_data_d  = pipe_valid_q ? pipe_data_q : rd_data_q;
            rd_valid_d = pipe_valid_q;
        end else begin
            rd_data_d  = rd_fire ? rd_word : rd_data_q;
            rd_valid_d = rd_fire;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= CLEAR;
            cnt_q        <= '0;
            pipe_data_q  <= '0;
            pipe_valid_q <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pipe_data_q  <= pipe_data_d;
            pipe_valid_q <= pipe_valid_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    // Array storage is never reset; only the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_wbe[i]) begin
                    mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_dp.sv
// tb_memory_dp: directed testbench for memory_dp. Four instances share one
// stimulus stream:
//   dut_a  DEPTH=16, RD_LAT=1, write-first
//   dut_b  DEPTH=16, RD_LAT=1, read-first
//   dut_c  DEPTH=16, RD_LAT=2, write-first
//   dut_d  DEPTH=12, ADDR=4, RD_LAT=1, write-first (low address bits only)
module tb_memory_dp;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_en;
    logic [7:0]  rd_addr;

    logic        busy_a, busy_b, busy_c, busy_d;
    logic [31:0] rd_data_a, rd_data_b, rd_data_c, rd_data_d;
    logic        rd_valid_a, rd_valid_b, rd_valid_c, rd_valid_d;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memory_dp #(.WIDTH(32), .DEPTH(16), .ADDR(8), .RD_LAT(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a)
    );

    memory_dp #(.WIDTH(32), .DEPTH(16), .ADDR(8), .RD_LAT(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
    );

    memory_dp #(.WIDTH(32), .DEPTH(16), .ADDR(8), .RD_LAT(2), .BYPASS(1)) dut_c (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_c),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_valid(rd_valid_c)
    );

    memory_dp #(.WIDTH(32), .DEPTH(12), .ADDR(4), .RD_LAT(1), .BYPASS(1)) dut_d (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_d),
        .wr_en(wr_en), .wr_addr(wr_addr[3:0]), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr[3:0]), .rd_data(rd_data_d), .rd_valid(rd_valid_d)
    );

    // Drive one cycle of port inputs, then wait until just after the edge.
    task automatic applyStimulus(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                                 input logic [3:0] be, input logic re, input logic [7:0] ra);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        wr_be   = be;
        rd_en   = re;
        rd_addr = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Bound on total run time in case a clock or edge never arrives.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] memory_dp directed test starting");
        rst = 1'b1; clr = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0;

        // Asynchronous reset, before any clock edge.
        #2 rst = 1'b0;
        #2;
        checkOutput("rst_busy_a", 32'(busy_a), 32'd1);
        checkOutput("rst_busy_c", 32'(busy_c), 32'd1);
        checkOutput("rst_valid_a", 32'(rd_valid_a), 32'd0);
        checkOutput("rst_data_a", rd_data_a, 32'h0);
        checkOutput("rst_data_c", rd_data_c, 32'h0);
        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd0);
        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd0);
        checkOutput("rst_hold_busy_a", 32'(busy_a), 32'd1);
        checkOutput("rst_hold_valid_a", 32'(rd_valid_a), 32'd0);

        // Reset sweep: busy lasts exactly DEPTH edges after release.
        rst = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b0, 8'd0);
            checkOutput("sweep_busy_a", 32'(busy_a), (i < 16) ? 32'd1 : 32'd0);
            checkOutput("sweep_busy_d", 32'(busy_d), (i < 12) ? 32'd1 : 32'd0);
        end

        // Back-to-back reads of the whole cleared array.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'(i));
            checkOutput("clr_rd_valid_a", 32'(rd_valid_a), 32'd1);
            checkOutput("clr_rd_data_a", rd_data_a, 32'h0);
        end
        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b0, 8'd0);
        checkOutput("idle_valid_a", 32'(rd_valid_a), 32'd0);

        // Byte enables.
        applyStimulus(1'b1, 8'd5, 32'hAABBCCDD, 4'hF, 1'b0, 8'd0);
        applyStimulus(1'b1, 8'd5, 32'h11223344, 4'b0101, 1'b0, 8'd0);
        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd5);
        checkOutput("be_data_a", rd_data_a, 32'hAA22CC44);
        checkOutput("be_valid_a", 32'(rd_valid_a), 32'd1);
        checkOutput("be_data_b", rd_data_b, 32'hAA22CC44);
        checkOutput("be_valid_c_early", 32'(rd_valid_c), 32'd0);
        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b0, 8'd0);
        checkOutput("be_data_c", rd_data_c, 32'hAA22CC44);
        checkOutput("be_valid_c", 32'(rd_valid_c), 32'd1);
        checkOutput("be_hold_data_a", rd_data_a, 32'hAA22CC44);
        checkOutput("be_fall_valid_a", 32'(rd_valid_a), 32'd0);

        // Read/write collision on address 3 (currently zero).
        applyStimulus(1'b1, 8'd3, 32'h12345678, 4'hF, 1'b1, 8'd3);
        checkOutput("col_wf_data_a", rd_data_a, 32'h12345678);
        checkOutput("col_rf_data_b", rd_data_b, 32'h00000000);
        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd3);
        checkOutput("col_after_a", rd_data_a, 32'h12345678);
        checkOutput("col_after_b", rd_data_b, 32'h12345678);
        checkOutput("col_wf_data_c", rd_data_c, 32'h12345678);
        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b0, 8'd0);
        checkOutput("col_after_c", rd_data_c, 32'h12345678);

        // Two-cycle latency with back-to-back reads.
        applyStimulus(1'b1, 8'd1, 32'h11111111, 4'hF, 1'b0, 8'd0);
        applyStimulus(1'b1, 8'd2, 32'h22222222, 4'hF, 1'b0, 8'd0);
        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd1);
        checkOutput("lat_e1_valid_c", 32'(rd_valid_c), 32'd0);
        checkOutput("lat_e1_data_a", rd_data_a, 32'h11111111);
        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd2);
        checkOutput("lat_e2_valid_c", 32'(rd_valid_c), 32'd1);
        checkOutput("lat_e2_data_c", rd_data_c, 32'h11111111);
        checkOutput("lat_e2_data_a", rd_data_a, 32'h22222222);
        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b0, 8'd0);
        checkOutput("lat_e3_valid_c", 32'(rd_valid_c), 32'd1);
        checkOutput("lat_e3_data_c", rd_data_c, 32'h22222222);
        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b0, 8'd0);
        checkOutput("lat_e4_valid_c", 32'(rd_valid_c), 32'd0);

        // Clear mid-run, then reset during the sweep.
        applyStimulus(1'b1, 8'd7, 32'h000000FF, 4'hF, 1'b0, 8'd0);
        checkOutput("pre_clr_busy_a", 32'(busy_a), 32'd0);
        clr = 1'b1;
        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b0, 8'd0);
        clr = 1'b0;
        checkOutput("clr_busy_a", 32'(busy_a), 32'd1);
        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b0, 8'd0);
        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b0, 8'd0);
        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b0, 8'd0);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_busy_a", 32'(busy_a), 32'd1);
        rst = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 8'd9, 32'hDEADBEEF, 4'hF, 1'b1, 8'd7);
            checkOutput("mid_busy_a", 32'(busy_a), (i < 16) ? 32'd1 : 32'd0);
            checkOutput("mid_valid_a", 32'(rd_valid_a), 32'd0);
        end
        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd9);
        checkOutput("mid_drop_valid_a", 32'(rd_valid_a), 32'd1);
        checkOutput("mid_drop_data_a", rd_data_a, 32'h0);
        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd7);
        checkOutput("mid_addr7_a", rd_data_a, 32'h0);

        // Out-of-range on the DEPTH=12 instance (in range for dut_a).
        applyStimulus(1'b1, 8'd13, 32'h13131313, 4'hF, 1'b0, 8'd0);
        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'd13);
        checkOutput("oor_valid_d", 32'(rd_valid_d), 32'd1);
        checkOutput("oor_data_d", rd_data_d, 32'h0);
        checkOutput("inr_data_a", rd_data_a, 32'h13131313);
        // dut_d was idle for the last sweep edges of dut_a, so addr 9 took DEADBEEF.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b1, 8'(i));
            checkOutput("oor_keep_valid_d", 32'(rd_valid_d), 32'd1);
            checkOutput("oor_keep_data_d", rd_data_d, (i == 9) ? 32'hDEADBEEF : 32'h0);
        end
        applyStimulus(1'b0, 8'd0, 32'h0, 4'h0, 1'b0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
